// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point/game-over state machine, scores, and the ball hold
// that keeps the ball at its start position outside live play.
module pong_match_ctrl #(
  parameter int unsigned SCREEN_WIDTH  = 800,
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned PAUSE_FRAMES  = 60,
  parameter int unsigned SERVE_TIMEOUT = 180
) (
  input  logic        pixelClock,
  input  logic        Reset,
  input  logic        frameTick,
  input  logic        serveBtn,
  input  logic [10:0] ballLeft,
  input  logic [10:0] ballRight,
  output logic        ballHold,
  output logic        serveRight,
  output logic [3:0]  scoreLeft,
  output logic [3:0]  scoreRight,
  output logic        gameOver,
  output logic [2:0]  ctrlState
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StServe = 3'd1;
  localparam logic [2:0] StPlay  = 3'd2;
  localparam logic [2:0] StPoint = 3'd3;
  localparam logic [2:0] StOver  = 3'd4;

  localparam logic [10:0] RightEdge = 11'(SCREEN_WIDTH);
  localparam logic [3:0]  WinScore  = 4'(WIN_SCORE);
  localparam logic [7:0]  PauseLast = 8'(PAUSE_FRAMES - 1);
  localparam logic [7:0]  ServeLast = 8'(SERVE_TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       serve_right_q, serve_right_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       hold_q;
  // [0],[1]: synchronizer; [2]: previous synchronized level for edge detect
  logic [2:0] sync_q;
  logic       serve_pulse;

  assign serve_pulse = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d       = state_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    serve_right_d = serve_right_q;

    case (state_q)
      StIdle: begin
        if (serve_pulse) begin
          score_l_d     = 4'd0;
          score_r_d     = 4'd0;
          serve_right_d = 1'b1;
          state_d       = StServe;
        end
      end
      StServe: begin
        if (serve_pulse || (frameTick && (frame_cnt_q == ServeLast))) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        // Left-edge miss takes priority if both edges are hit in the same cycle
        if (ballLeft <= 11'd1) begin
          score_r_d     = (score_r_q < WinScore) ? score_r_q + 4'd1 : score_r_q;
          serve_right_d = 1'b0;
          state_d       = StPoint;
        end else if (ballRight >= RightEdge) begin
          score_l_d     = (score_l_q < WinScore) ? score_l_q + 4'd1 : score_l_q;
          serve_right_d = 1'b1;
          state_d       = StPoint;
        end
      end
      StPoint: begin
        if (frameTick && (frame_cnt_q == PauseLast)) begin
          if ((score_l_q == WinScore) || (score_r_q == WinScore)) begin
            state_d = StOver;
          end else begin
            state_d = StServe;
          end
        end
      end
      StOver: begin
        if (serve_pulse) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A tick coinciding with a state change is absorbed by the clear
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (frameTick && (frame_cnt_q != 8'hff)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge pixelClock or posedge Reset) begin
    if (Reset) begin
      state_q       <= StIdle;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      serve_right_q <= 1'b1;
      frame_cnt_q   <= 8'd0;
      hold_q        <= 1'b1;
      sync_q        <= 3'b000;
    end else begin
      state_q       <= state_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      serve_right_q <= serve_right_d;
      frame_cnt_q   <= frame_cnt_d;
      hold_q        <= (state_d != StPlay);
      sync_q        <= {sync_q[1:0], serveBtn};
    end
  end

  assign ballHold   = hold_q;
  assign serveRight = serve_right_q;
  assign scoreLeft  = score_l_q;
  assign scoreRight = score_r_q;
  assign gameOver   = (state_q == StOver);
  assign ctrlState  = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: table of per-cycle stimulus with expected outputs fed through a
// scoreboard queue, plus hand-written reset checks.
module tb_pong_match_ctrl;

  logic        pixelClock = 1'b0;
  logic        Reset;
  logic        frameTick;
  logic        serveBtn;
  logic [10:0] ballLeft;
  logic [10:0] ballRight;
  logic        ballHold;
  logic        serveRight;
  logic [3:0]  scoreLeft;
  logic [3:0]  scoreRight;
  logic        gameOver;
  logic [2:0]  ctrlState;

  pong_match_ctrl #(
    .SCREEN_WIDTH (800),
    .WIN_SCORE    (2),
    .PAUSE_FRAMES (2),
    .SERVE_TIMEOUT(3)
  ) dut (
    .pixelClock(pixelClock),
    .Reset     (Reset),
    .frameTick (frameTick),
    .serveBtn  (serveBtn),
    .ballLeft  (ballLeft),
    .ballRight (ballRight),
    .ballHold  (ballHold),
    .serveRight(serveRight),
    .scoreLeft (scoreLeft),
    .scoreRight(scoreRight),
    .gameOver  (gameOver),
    .ctrlState (ctrlState)
  );

  always #5 pixelClock = ~pixelClock;

  typedef struct {
    logic        f;
    logic        b;
    logic [10:0] l;
    logic [10:0] r;
    logic [2:0]  st;
    logic        sr;
    logic [3:0]  sl;
    logic [3:0]  srt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected outputs after the next row's clock edge
  logic [2:0] e_st;
  logic       e_sr;
  logic [3:0] e_sl, e_srt;

  task automatic add(input logic f, input logic b, input logic [10:0] l, input logic [10:0] r);
    vec_t v;
    v.f = f; v.b = b; v.l = l; v.r = r;
    v.st = e_st; v.sr = e_sr; v.sl = e_sl; v.srt = e_srt;
    tbl.push_back(v);
  endtask

  task automatic idle_row(input logic f);
    add(f, 1'b0, 11'd400, 11'd416);
  endtask

  // One-cycle press: state changes on the third edge
  task automatic press(input logic [2:0] nxt);
    add(1'b0, 1'b1, 11'd400, 11'd416);
    idle_row(1'b0);
    e_st = nxt;
    if (nxt == 3'd1 && tbl[tbl.size()-1].st == 3'd0) begin
      e_sl = 4'd0; e_srt = 4'd0; e_sr = 1'b1;
    end
    idle_row(1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic sb_check(input int idx);
    vec_t e;
    e = exp_q.pop_front();
    chk($sformatf("row%0d.ctrlState", idx), 32'(ctrlState), 32'(e.st));
    chk($sformatf("row%0d.ballHold", idx), 32'(ballHold), 32'(e.st != 3'd2));
    chk($sformatf("row%0d.gameOver", idx), 32'(gameOver), 32'(e.st == 3'd4));
    chk($sformatf("row%0d.serveRight", idx), 32'(serveRight), 32'(e.sr));
    chk($sformatf("row%0d.scoreLeft", idx), 32'(scoreLeft), 32'(e.sl));
    chk($sformatf("row%0d.scoreRight", idx), 32'(scoreRight), 32'(e.srt));
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, ".ctrlState"}, 32'(ctrlState), 32'd0);
    chk({tag, ".ballHold"}, 32'(ballHold), 32'd1);
    chk({tag, ".gameOver"}, 32'(gameOver), 32'd0);
    chk({tag, ".serveRight"}, 32'(serveRight), 32'd1);
    chk({tag, ".scoreLeft"}, 32'(scoreLeft), 32'd0);
    chk({tag, ".scoreRight"}, 32'(scoreRight), 32'd0);
  endtask

  initial begin
    // Build the stimulus table
    e_st = 3'd0; e_sr = 1'b1; e_sl = 4'd0; e_srt = 4'd0;
    // Held button for 10 clocks: exactly one IDLE->SERVE, on the 3rd edge
    for (int i = 0; i < 10; i++) begin
      if (i == 2) e_st = 3'd1;
      add(1'b0, 1'b1, 11'd400, 11'd416);
    end
    for (int i = 0; i < 3; i++) idle_row(1'b0);
    press(3'd2);
    // Right-edge point, pause of two frames, back to SERVE
    e_st = 3'd3; e_sl = 4'd1; e_sr = 1'b1;
    add(1'b0, 1'b0, 11'd400, 11'd800);
    idle_row(1'b1);
    e_st = 3'd1;
    idle_row(1'b1);
    // Auto-serve on the 3rd frame tick
    idle_row(1'b1);
    idle_row(1'b1);
    e_st = 3'd2;
    idle_row(1'b1);
    // Second left point wins
    e_st = 3'd3; e_sl = 4'd2;
    add(1'b0, 1'b0, 11'd400, 11'd800);
    idle_row(1'b1);
    e_st = 3'd4;
    idle_row(1'b1);
    idle_row(1'b1);
    press(3'd0);
    press(3'd1);
    press(3'd2);
    // Left-edge point
    e_st = 3'd3; e_srt = 4'd1; e_sr = 1'b0;
    add(1'b0, 1'b0, 11'd1, 11'd17);
    idle_row(1'b1);
    e_st = 3'd1;
    idle_row(1'b1);
    // Button pulse coincides with the timeout tick: single move to PLAY
    idle_row(1'b1);
    idle_row(1'b1);
    add(1'b0, 1'b1, 11'd400, 11'd416);
    idle_row(1'b0);
    e_st = 3'd2;
    idle_row(1'b1);
    idle_row(1'b0);
    // Both edges at once: only the right player scores
    e_st = 3'd3; e_srt = 4'd2; e_sr = 1'b0;
    add(1'b0, 1'b0, 11'd0, 11'd800);
    idle_row(1'b1);
    e_st = 3'd4;
    idle_row(1'b1);
    press(3'd0);
    press(3'd1);
    press(3'd2);
    e_st = 3'd3; e_sl = 4'd1; e_sr = 1'b1;
    add(1'b0, 1'b0, 11'd400, 11'd800);
    idle_row(1'b1);
    e_st = 3'd1;
    idle_row(1'b1);
    press(3'd2);

    // Reset state
    Reset = 1'b1; frameTick = 1'b0; serveBtn = 1'b0;
    ballLeft = 11'd400; ballRight = 11'd416;
    repeat (2) @(posedge pixelClock);
    #1;
    check_reset_outs("reset");
    @(negedge pixelClock);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge pixelClock);
      frameTick = tbl[i].f;
      serveBtn  = tbl[i].b;
      ballLeft  = tbl[i].l;
      ballRight = tbl[i].r;
      exp_q.push_back(tbl[i]);
      @(posedge pixelClock);
      #1;
      sb_check(i);
    end

    // Mid-play asynchronous reset takes effect before the next edge
    @(negedge pixelClock);
    frameTick = 1'b0; serveBtn = 1'b0;
    chk("preabort.ctrlState", 32'(ctrlState), 32'd2);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outs("abort");
    @(negedge pixelClock);
    Reset = 1'b0;
    @(posedge pixelClock);
    #1;
    chk("post_abort.ctrlState", 32'(ctrlState), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
